// File: rtl/matrix_mac_stream_4x4.sv
// matrix_mac_stream_4x4: streams operands A then B in, computes C = A x B on one MAC,
// and streams C out row-major, one element per valid/ready handshake.
module matrix_mac_stream_4x4 #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int OW = 2*DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    localparam int NN = N*N;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(NN);
    localparam int LW = $clog2(2*NN);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q [NN];
    logic [DW-1:0]   b_q [NN];
    logic [OW-1:0]   c_q [NN];
    logic [LW-1:0]   load_cnt_q;
    logic [CW-1:0]   i_q, j_q, k_q;
    logic [IW-1:0]   idx_q, idx_d;
    logic [OW-1:0]   acc_q, sum;
    logic [2*DW-1:0] prod;
    logic [IW-1:0]   a_idx, b_idx, c_idx;
    logic            in_ready_q, out_valid_q, out_last_q, busy_q;
    logic            accept, out_hs, load_last, idx_last;
    logic            i_last, j_last, k_last, mac_last;

    assign accept    = in_valid & in_ready_q;
    assign out_hs    = out_valid_q & out_ready;
    assign load_last = load_cnt_q == LW'(2*NN-1);
    assign idx_last  = idx_q == IW'(NN-1);
    assign i_last    = i_q == CW'(N-1);
    assign j_last    = j_q == CW'(N-1);
    assign k_last    = k_q == CW'(N-1);
    assign mac_last  = i_last & j_last & k_last;

    assign a_idx = IW'(i_q) * IW'(N) + IW'(k_q);
    assign b_idx = IW'(k_q) * IW'(N) + IW'(j_q);
    assign c_idx = IW'(i_q) * IW'(N) + IW'(j_q);
    assign prod  = a_q[a_idx] * b_q[b_idx];
    assign sum   = acc_q + OW'(prod);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = out_valid_q ? c_q[idx_q] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    state_d = (accept && load_last) ? COMPUTE : LOAD;
            COMPUTE: state_d = mac_last ? DRAIN : COMPUTE;
            DRAIN: begin
                idx_d   = out_hs ? (idx_last ? '0 : idx_q + IW'(1)) : idx_q;
                state_d = (out_hs && idx_last) ? LOAD : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= state_d == LOAD;
            out_valid_q <= state_d == DRAIN;
            out_last_q  <= (state_d == DRAIN) && (idx_d == IW'(NN-1));
            busy_q      <= (state_d == COMPUTE) || (state_d == DRAIN);
            if (accept) begin
                load_cnt_q <= load_last ? '0 : load_cnt_q + LW'(1);
                if (load_cnt_q < LW'(NN))
                    a_q[load_cnt_q[IW-1:0]] <= in_data;
                else
                    b_q[IW'(load_cnt_q - LW'(NN))] <= in_data;
            end
            if (state_q == COMPUTE) begin
                k_q   <= k_last ? '0 : k_q + CW'(1);
                acc_q <= k_last ? '0 : sum;
                if (k_last) begin
                    j_q        <= j_last ? '0 : j_q + CW'(1);
                    c_q[c_idx] <= sum;
                end
                if (k_last && j_last)
                    i_q <= i_last ? '0 : i_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_matrix_mac_stream_4x4.sv
// tb_matrix_mac_stream_4x4: directed and randomized matrix pairs checked against a
// plain-arithmetic matrix product model.
module tb_matrix_mac_stream_4x4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid, out_last, busy;
    logic [17:0] out_data;
    int tests = 0;
    int fails = 0;
    int ma[16], mb[16], mc[16];

    always #5 clk = ~clk;

    matrix_mac_stream_4x4 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) s += ma[i*4+k] * mb[k*4+j];
                mc[i*4+j] = s & 32'h3FFFF;
            end
    endfunction

    function automatic void set_mats(input int amode, input int bmode);
        for (int n = 0; n < 16; n++) begin
            ma[n] = amode == 0 ? ((n % 5 == 0) ? 1 : 0) :
                    amode == 1 ? ((n % 5 == 0) ? 2 : 0) :
                    amode == 2 ? 255 : amode == 3 ? 1 : int'($urandom_range(0, 255));
            mb[n] = bmode == 0 ? n + 1 : bmode == 1 ? ((n % 5 == 0) ? 1 : 0) :
                    bmode == 2 ? 255 : bmode == 3 ? 2 : int'($urandom_range(0, 255));
        end
        model();
    endfunction

    task automatic load_pair(input bit gaps);
        int e = 0;
        int guard = 0;
        logic acc;
        while (e < 32 && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = 8'(e < 16 ? ma[e] : mb[(e - 16) & 15]);
            acc = in_valid && in_ready;
            tick();
            if (acc) e++;
            guard++;
        end
        in_valid = 1'b0;
        check("load_count", e, 32);
    endtask

    task automatic wait_result();
        int n = 0;
        bit rdy_seen = 0;
        check("busy_compute", busy, 1);
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen = 1;
            tick();
            n++;
        end
        check("latency", n, 64);
        check("in_ready_compute", rdy_seen, 0);
    endtask

    task automatic drain(input int mode);
        int idx = 0;
        int cyc = 0;
        logic hs;
        while (idx < 16 && cyc < 500) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
                        1'($urandom_range(0, 1));
            check("out_valid", out_valid, 1);
            check($sformatf("out_data[%0d]", idx), out_data, mc[idx]);
            check("out_last", out_last, idx == 15);
            hs = out_valid && out_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        out_ready = 1'b0;
        check("drain_count", idx, 16);
        check("out_valid_after", out_valid, 0);
        check("out_last_after", out_last, 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic run_pair(input int amode, input int bmode, input bit gaps, input int rmode);
        set_mats(amode, bmode);
        load_pair(gaps);
        wait_result();
        drain(rmode);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();
        check("load_after_reset", in_ready, 1);

        run_pair(0, 0, 0, 0);
        run_pair(2, 2, 0, 0);
        check("model_255", mc[5], 260100);
        run_pair(3, 3, 0, 1);
        run_pair(4, 4, 1, 2);
        run_pair(4, 4, 1, 1);

        set_mats(4, 4);
        load_pair(0);
        repeat (30) tick();
        check("busy_mid_compute", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_out_valid", out_valid, 0);
        run_pair(0, 1, 0, 0);

        run_pair(0, 0, 0, 0);
        run_pair(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
